// File: rtl/arb2x1_rr_stream_pkg.sv
// arb2x1_rr_stream_pkg
// Shared definitions for the two-input round-robin packet arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE, LOCK0, LOCK1); 2'd3 is unused
//                 and the FSM falls back to IDLE if it ever appears.
//   CH0 / CH1   : channel identifiers used for the grant, select and pointer.
package arb2x1_rr_stream_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_e;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/arb2x1_rr_stream_if.sv
// arb2x1_rr_stream_if
// Bundles the two input streams, the output stream and the mux select.
//   a0_valid/a0_data/a0_last/a0_ready : input channel 0
//   a1_valid/a1_data/a1_last/a1_ready : input channel 1
//   y_valid/y_data/y_last/y_ready     : output stream towards the consumer
//   s                                 : current/last granted channel
// Modports:
//   slave  : the arbiter's view (consumes a0/a1, produces y and s)
//   master : the surrounding environment's view (sources and consumer)
interface arb2x1_rr_stream_if #(
    parameter int WIDTH = 8
);

    logic             a0_valid;
    logic [WIDTH-1:0] a0_data;
    logic             a0_last;
    logic             a0_ready;

    logic             a1_valid;
    logic [WIDTH-1:0] a1_data;
    logic             a1_last;
    logic             a1_ready;

    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_last;
    logic             y_ready;

    logic             s;

    modport slave (
        input  a0_valid, a0_data, a0_last,
        output a0_ready,
        input  a1_valid, a1_data, a1_last,
        output a1_ready,
        output y_valid, y_data, y_last,
        input  y_ready,
        output s
    );

    modport master (
        output a0_valid, a0_data, a0_last,
        input  a0_ready,
        output a1_valid, a1_data, a1_last,
        input  a1_ready,
        input  y_valid, y_data, y_last,
        output y_ready,
        input  s
    );

endinterface

// File: rtl/arb2x1_rr_stream_mux2xN_case_default.sv
// mux2xN_case_default
// N-bit 2:1 multiplexer written as a case statement with a default arm.
//   s   : select (0 -> in0, 1 -> in1)
//   in0 : first input
//   in1 : second input
//   y   : selected value
module mux2xN_case_default #(
    parameter int N = 9
) (
    input  logic         s,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    output logic [N-1:0] y
);

    always_comb begin
        y = in0;
        case (s)
            1'b0:    y = in0;
            1'b1:    y = in1;
            default: y = in0;
        endcase
    end

endmodule

// File: rtl/arb2x1_rr_stream.sv
// arb2x1_rr_stream
// Two-input round-robin packet arbiter feeding a one-entry output slice.
// A granted channel owns the output until its last beat is accepted; the
// round-robin pointer moves only when a packet completes.
//   WIDTH : data bits per beat
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : arb2x1_rr_stream_if.slave (a0/a1 inputs, y output, select s)
module arb2x1_rr_stream
    import arb2x1_rr_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    arb2x1_rr_stream_if.slave    bus
);

    arb_state_e       state;
    arb_state_e       state_next;
    logic             ptr;
    logic             ptr_next;
    logic             s_q;
    logic             s_next;
    logic             grant;

    logic             y_valid_q;
    logic [WIDTH-1:0] y_data_q;
    logic             y_last_q;

    logic             slot_free;
    logic             ready0;
    logic             ready1;
    logic             accept0;
    logic             accept1;
    logic             load;
    logic [WIDTH:0]   sel_beat;

    // s always equals the locked channel while in LOCK0/LOCK1, so it can
    // drive the data mux directly.
    mux2xN_case_default #(
        .N   (WIDTH + 1)
    ) u_mux (
        .s   (s_q),
        .in0 ({bus.a0_last, bus.a0_data}),
        .in1 ({bus.a1_last, bus.a1_data}),
        .y   (sel_beat)
    );

    // The slice can take a beat when it is empty or being drained now.
    assign slot_free = !y_valid_q || bus.y_ready;
    assign ready0    = (state == ARB_LOCK0) && slot_free;
    assign ready1    = (state == ARB_LOCK1) && slot_free;
    assign accept0   = bus.a0_valid && ready0;
    assign accept1   = bus.a1_valid && ready1;
    assign load      = accept0 || accept1;

    // On contention the pointer decides; otherwise the lone requester wins.
    assign grant = (bus.a0_valid && bus.a1_valid) ? ptr : bus.a1_valid;

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        s_next     = s_q;
        case (state)
            ARB_IDLE: begin
                if (bus.a0_valid || bus.a1_valid) begin
                    s_next     = grant;
                    state_next = grant ? ARB_LOCK1 : ARB_LOCK0;
                end
            end
            ARB_LOCK0: begin
                if (accept0 && bus.a0_last) begin
                    state_next = ARB_IDLE;
                    ptr_next   = CH1;
                end
            end
            ARB_LOCK1: begin
                if (accept1 && bus.a1_last) begin
                    state_next = ARB_IDLE;
                    ptr_next   = CH0;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // A new beat takes priority over draining so load and drain can overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            ptr       <= CH0;
            s_q       <= CH0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_last_q  <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            s_q   <= s_next;
            if (load) begin
                y_valid_q <= 1'b1;
                y_last_q  <= sel_beat[WIDTH];
                y_data_q  <= sel_beat[WIDTH-1:0];
            end else if (bus.y_ready) begin
                y_valid_q <= 1'b0;
            end
        end
    end

    assign bus.a0_ready = ready0;
    assign bus.a1_ready = ready1;
    assign bus.y_valid  = y_valid_q;
    assign bus.y_data   = y_data_q;
    assign bus.y_last   = y_last_q;
    assign bus.s        = s_q;

endmodule

// File: tb/tb_arb2x1_rr_stream.sv
// tb_arb2x1_rr_stream
// Testbench for arb2x1_rr_stream: directed packet scenarios followed by
// randomized traffic, with a behavioural model of the arbiter.
module tb_arb2x1_rr_stream;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    arb2x1_rr_stream_if #(.WIDTH(WIDTH)) bus ();

    arb2x1_rr_stream #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Pending beats per source, each stored as {last, data}.
    logic [WIDTH:0]   q0[$];
    logic [WIDTH:0]   q1[$];
    bit               en0, en1, yr;

    // Behavioural model: lock is -1 when no channel owns the output.
    int               m_lock;
    bit               m_ptr;
    bit               m_s;
    bit               m_yv;
    bit               m_yl;
    logic [WIDTH-1:0] m_yd;
    int               acc_count;

    // Observation logs.
    logic [WIDTH-1:0] out_log[$];
    logic [WIDTH-1:0] exp_q[$];
    bit               trace_on;
    bit               tr_v[$];
    logic [WIDTH-1:0] tr_d[$];
    bit               tr_s[$];
    bit               bp_check;
    bit               rst_check;

    bit               cont_v[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [WIDTH-1:0] cont_d[6] = '{8'h11, 8'h12, 8'h13, 8'h00, 8'h21, 8'h22};

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH:0] beat(input bit last, input logic [WIDTH-1:0] data);
        return {last, data};
    endfunction

    // Present the head of each source queue to the arbiter.
    task automatic applyStimulus();
        logic [WIDTH:0] h0, h1;
        h0 = (q0.size() > 0) ? q0[0] : '0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        bus.a0_valid = en0 && (q0.size() > 0);
        bus.a0_data  = h0[WIDTH-1:0];
        bus.a0_last  = h0[WIDTH];
        bus.a1_valid = en1 && (q1.size() > 0);
        bus.a1_data  = h1[WIDTH-1:0];
        bus.a1_last  = h1[WIDTH];
        bus.y_ready  = yr;
    endtask

    task automatic modelReset();
        m_lock = -1;
        m_ptr  = 1'b0;
        m_s    = 1'b0;
        m_yv   = 1'b0;
        m_yl   = 1'b0;
        m_yd   = '0;
    endtask

    // One clock cycle: drive, compare at the falling edge, advance the model.
    task automatic cycle();
        bit             v0, v1, r0, r1, acc, loaded;
        logic [WIDTH:0] b;
        int             g;
        applyStimulus();
        v0 = bus.a0_valid;
        v1 = bus.a1_valid;
        @(negedge clk);
        r0 = (m_lock == 0) && (!m_yv || yr);
        r1 = (m_lock == 1) && (!m_yv || yr);
        checkOutput("a0_ready", bus.a0_ready, r0);
        checkOutput("a1_ready", bus.a1_ready, r1);
        checkOutput("y_valid", bus.y_valid, m_yv);
        checkOutput("y_data", bus.y_data, m_yd);
        checkOutput("y_last", bus.y_last, m_yl);
        checkOutput("s", bus.s, m_s);
        if (bp_check) begin
            checkOutput("bp_y_data", bus.y_data, 8'h11);
            checkOutput("bp_y_valid", bus.y_valid, 1);
            checkOutput("bp_a0_ready", bus.a0_ready, 0);
        end
        if (rst_check) checkOutput("rst_mid_y_valid", bus.y_valid, 0);
        if (bus.y_valid && yr) out_log.push_back(bus.y_data);
        if (trace_on) begin
            tr_v.push_back(bus.y_valid);
            tr_d.push_back(bus.y_data);
            tr_s.push_back(bus.s);
        end
        if (rst) begin
            modelReset();
        end else begin
            loaded = 1'b0;
            if (m_lock < 0) begin
                if (v0 || v1) begin
                    g      = (v0 && v1) ? int'(m_ptr) : (v1 ? 1 : 0);
                    m_lock = g;
                    m_s    = (g == 1);
                end
            end else begin
                acc = (m_lock == 0) ? (v0 && r0) : (v1 && r1);
                if (acc) begin
                    b = (m_lock == 0) ? q0.pop_front() : q1.pop_front();
                    acc_count++;
                    m_yd   = b[WIDTH-1:0];
                    m_yl   = b[WIDTH];
                    loaded = 1'b1;
                    if (b[WIDTH]) begin
                        m_ptr  = (m_lock == 0);
                        m_lock = -1;
                    end
                end
            end
            if (loaded) m_yv = 1'b1;
            else if (m_yv && yr) m_yv = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic checkLog(input string tag);
        checkOutput({tag, "_count"}, out_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
            checkOutput($sformatf("%s_beat%0d", tag, i), out_log[i], exp_q[i]);
    endtask

    task automatic pushRandomPacket(input int ch);
        int n;
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) begin
            if (ch == 0) q0.push_back(beat(i == n - 1, WIDTH'($urandom)));
            else         q1.push_back(beat(i == n - 1, WIDTH'($urandom)));
        end
    endtask

    // Directed scenarios first, then randomized traffic.
    initial begin
        int               k;
        int               guard;
        logic [WIDTH-1:0] d;
        modelReset();
        acc_count = 0;
        bp_check  = 0;
        rst_check = 0;
        trace_on  = 0;

        // Reset held with both sources requesting, then contention.
        q0 = {beat(0, 8'h11), beat(0, 8'h12), beat(1, 8'h13)};
        q1 = {beat(0, 8'h21), beat(1, 8'h22)};
        en0 = 1; en1 = 1; yr = 1; rst = 1;
        applyStimulus();
        @(posedge clk);
        #1;
        runCycles(2);
        rst = 0;
        trace_on = 1;
        runCycles(12);
        trace_on = 0;
        k = -1;
        foreach (tr_v[i]) if (k < 0 && tr_v[i]) k = i;
        checkOutput("cont_window", (k >= 0) && (k + 6 <= tr_v.size()), 1);
        if (k >= 0 && k + 6 <= tr_v.size()) begin
            for (int i = 0; i < 6; i++) begin
                checkOutput($sformatf("cont_valid%0d", i), tr_v[k + i], cont_v[i]);
                if (cont_v[i]) checkOutput($sformatf("cont_data%0d", i), tr_d[k + i], cont_d[i]);
            end
        end
        exp_q = {8'h11, 8'h12, 8'h13, 8'h21, 8'h22};
        checkLog("cont");

        // After a1 finishes, the pointer favours a0 again.
        out_log.delete();
        q0 = {beat(1, 8'h31)};
        q1 = {beat(1, 8'h41)};
        runCycles(8);
        exp_q = {8'h31, 8'h41};
        checkLog("rr_next");

        // Backpressure on the first beat of an a0 packet.
        en0 = 0; en1 = 0;
        runCycles(3);
        out_log.delete();
        q0 = {beat(0, 8'h11), beat(0, 8'h12), beat(1, 8'h13)};
        en0 = 1;
        runCycles(2);
        yr = 0; bp_check = 1;
        runCycles(4);
        yr = 1; bp_check = 0;
        runCycles(6);
        exp_q = {8'h11, 8'h12, 8'h13};
        checkLog("bp");

        // Alternating single-beat packets from a fresh reset.
        en0 = 0; rst = 1;
        runCycles(1);
        rst = 0;
        out_log.delete();
        tr_v.delete(); tr_d.delete(); tr_s.delete();
        q0 = {beat(1, 8'h51), beat(1, 8'h52), beat(1, 8'h53)};
        q1 = {beat(1, 8'h61), beat(1, 8'h62)};
        en0 = 1; en1 = 1; trace_on = 1;
        runCycles(16);
        trace_on = 0;
        exp_q = {8'h51, 8'h61, 8'h52, 8'h62, 8'h53};
        checkLog("single");
        for (int i = 1; i < tr_v.size(); i++) begin
            if (tr_v[i]) begin
                d = tr_d[i];
                checkOutput($sformatf("single_s_lead%0d", i), tr_s[i - 1], d[7:4] == 4'h6);
            end
        end

        // a0 pauses mid-packet while a1 waits.
        out_log.delete();
        q0 = {beat(0, 8'h71), beat(0, 8'h72), beat(1, 8'h73)};
        q1 = {beat(1, 8'h81)};
        en0 = 1; en1 = 0;
        runCycles(1);
        en1 = 1;
        runCycles(1);
        en0 = 0;
        runCycles(2);
        en0 = 1;
        runCycles(10);
        exp_q = {8'h71, 8'h72, 8'h73, 8'h81};
        checkLog("gap");

        // Reset in the middle of an a0 packet while the pointer favours a1.
        out_log.delete();
        q0 = {beat(1, 8'h90), beat(0, 8'h91), beat(0, 8'h92), beat(0, 8'h93), beat(1, 8'h94)};
        en0 = 1; en1 = 0;
        acc_count = 0;
        guard = 0;
        while (acc_count < 3 && guard < 20) begin
            cycle();
            guard++;
        end
        checkOutput("rst_mid_reach", acc_count, 3);
        rst = 1;
        runCycles(1);
        rst = 0;
        q0.delete(); q1.delete();
        q0 = {beat(1, 8'hA1)};
        q1 = {beat(1, 8'hB1)};
        en0 = 1; en1 = 1;
        out_log.delete();
        rst_check = 1;
        runCycles(1);
        rst_check = 0;
        runCycles(8);
        exp_q = {8'hA1, 8'hB1};
        checkLog("rst_mid");

        // Randomized traffic with random gaps and backpressure.
        rst = 1;
        runCycles(1);
        rst = 0;
        q0.delete(); q1.delete();
        for (int i = 0; i < 2000; i++) begin
            if (q0.size() < 3) pushRandomPacket(0);
            if (q1.size() < 3) pushRandomPacket(1);
            en0 = ($urandom_range(0, 3) != 0);
            en1 = ($urandom_range(0, 3) != 0);
            yr  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb2x1_rr_stream.md
# arb2x1_rr_stream

Two-input round-robin packet arbiter that feeds a single output stream. It drives the select for a 2:1 data mux and registers the winning beat into a one-entry output slice. It sits directly upstream of the output consumer and owns the select line: `s=0` passes channel a0 and `s=1` passes channel a1. Arbitration is per packet, so a granted input keeps the output until its `last` beat is accepted.

## Interface
- `WIDTH`, default 8: data bits per beat.

- `clk`  in  1  clock. All logic is rising-edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `a0_valid`  in  1  channel 0 beat available.
- `a0_data`  in  WIDTH  channel 0 beat.
- `a0_last`  in  1  channel 0 final beat of packet.
- `a0_ready`  out  1  channel 0 beat accepted this cycle when high with `a0_valid`.
- `a1_valid`, `a1_data`, `a1_last`, `a1_ready`: same as channel 0, for channel 1.
- `y_valid`  out  1  output beat present.
- `y_data`  out  WIDTH  output beat.
- `y_last`  out  1  output final beat.
- `y_ready`  in  1  consumer accepts the beat when high with `y_valid`.
- `s`  out  1  current/last granted channel (mux select).

## Operation
- State machine:
  - IDLE
    - Only in IDLE, if any `aN_valid`: grant goes to the valid channel.
    - If both are valid, grant goes to `ptr`.
    - Next state is LOCK0 or LOCK1, and `s` is loaded with the grant.
    - If neither is valid: stay in IDLE.
  - LOCK0 / LOCK1
    - Only the locked channel may see ready: `aN_ready = lockN && (!y_valid || y_ready)`.
    - A beat is accepted when `aN_valid && aN_ready`.
    - An accepted beat is loaded into `y_data`/`y_last`, and `y_valid` is set to 1.
    - An accepted beat with `last=1` causes: next state IDLE, `ptr` set to the other channel.
- Output slice:
  - If `y_valid && y_ready` and no new beat is loaded, then `y_valid` goes to 0.
  - Load and drain can happen in the same cycle, which gives full throughput.
- Requests from the non-locked channel are ignored until the packet ends.
- If the locked channel drops valid mid-packet, the lock is held and the block waits.
- Single-beat packet (`last` on the first beat): LOCK for one accept, then back to IDLE.
- `s` is held in IDLE. `y_data`/`y_last` hold when not loaded.
- Round-robin: `ptr` flips only on packet completion, never on grant.

## Timing
- Reset values:
  - state IDLE, `ptr=0`, `s=0`
  - `y_valid=0`, `y_data=0`, `y_last=0`
  - `a0_ready=0`, `a1_ready=0`
- Reset mid-packet: in-flight beat in the output slice is discarded, lock is dropped, priority returns to a0.
- Grant latency: valid seen in IDLE at cycle t, then locked channel ready is earliest at t+1. This means one bubble per packet.
- Data latency: beat accepted at cycle t, visible on `y_*` at t+1.
- Backpressure: while `y_valid=1 && y_ready=0`, both readies are 0 and `y_*` is stable.
- Sustained throughput inside a packet: one beat per cycle when `y_ready=1`.
- Last beat accepted at t: IDLE at t+1, next grant at t+1, next channel ready at t+2.

## Structure
- Shared package holds the state encodings: `ARB_IDLE=2'd0`, `ARB_LOCK0=2'd1`, `ARB_LOCK1=2'd2`. Encoding 2'd3 is illegal and recovers to IDLE.
- One sub-module, `mux2xN_case_default`:
  - WIDTH+1-bit 2:1 case mux with a default arm, selecting {last,data} by `s`.
  - The FSM, pointer and output slice stay in the top module.

## Test plan
- Reset check: hold `rst=1` 2 cycles with both valids high, then all outputs are 0 and both readies are 0. Release, then `s=0` and a0 is granted first.
- Contention:
  - Stimulus: a0 sends 3 beats (0x11, 0x12, 0x13 with last), a1 sends 2 beats (0x21, 0x22 with last), both continuously valid, `y_ready=1`.
  - Required output: 0x11, 0x12, 0x13, bubble, 0x21, 0x22.
  - Next packet goes to a0.
- Backpressure: hold `y_ready=0` for 4 cycles after the first beat (0x11). `y_data` stays 0x11, `y_valid=1`, `a0_ready=0`, no beat is lost or duplicated.
- Single-beat packets:
  - Stimulus: alternating 1-beat packets, both valid.
  - Required response: grants alternate 0,1,0,1, and `s` tracks each grant one cycle before its data appears.
- Mid-packet gap: a0 drops valid for 2 cycles between beats while a1 is valid. Lock holds on a0, and a1 is not served until a0 `last` is accepted.
- Reset mid-packet: assert `rst` after 2 of 4 a0 beats. `y_valid=0` next cycle, and after release a fresh arbitration starts with `ptr=0`.
